tft_spi_monitor: RTL and testbench
==================================

TFT_SPI_MONITOR -- requirements
Module: tft_spi_monitor

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on each SPI input (minimum 2).
REQ-002 SHALL have parameter MAX_X, default 319: reset value of window end column.
REQ-003 SHALL have parameter MAX_Y, default 479: reset value of window end row.
REQ-004 clk  in  1  single system clock; all logic on its rising edge; SPI pins are sampled by it (no SPI-clock domain).
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 spi_clk  in  1  SPI clock from the TFT transmitter (mode 0, data sampled on rising edge).
REQ-007 spi_mosi  in  1  serial data, MSB first.
REQ-008 spi_dc  in  1  0 = command byte, 1 = data byte.
REQ-009 spi_cs  in  1  active-low chip select; may be tied 0.
REQ-010 byte_valid  out  1  one-cycle pulse per received byte.
REQ-011 byte_data  out  8  last received byte.
REQ-012 byte_dc  out  1  dc level sampled with bit 0 of that byte.
REQ-013 cmd_valid  out  1  one-cycle pulse per command byte.
REQ-014 cmd_code  out  8  last command byte.
REQ-015 win_x0, win_x1, win_y0, win_y1  out  16 each  committed address window.
REQ-016 pix_valid  out  1  one-cycle pulse per completed RGB565 pixel.
REQ-017 pix_x, pix_y  out  16 each  coordinate of that pixel.
REQ-018 pix_data  out  16  pixel value, first byte in [15:8].

Function
REQ-019 spi_clk, spi_mosi, spi_dc, spi_cs SHALL pass through SYNC_STAGES flops; rising edge of spi_clk detected from the last two synchronized samples.
REQ-020 On each detected edge with cs low, mosi SHALL shift into an 8-bit register, MSB first; a 3-bit counter counts bits.
REQ-021 byte_valid SHALL assert the cycle after the 8th edge is detected; byte_data/byte_dc hold until next byte.
REQ-022 cs high (synchronized) SHALL clear the bit counter, discarding a partial byte; cs high SHALL NOT alter decoder state.
REQ-023 Decoder FSM states: IDLE, CASET, PASET, RAMWR; a byte with dc=0 SHALL always pulse cmd_valid in the same cycle as byte_valid and set the next state: 0x2A->CASET, 0x2B->PASET, 0x2C->RAMWR, others->IDLE.
REQ-024 CASET/PASET SHALL collect 4 data bytes into a staging register (x0 hi, x0 lo, x1 hi, x1 lo) and commit to win_x*/win_y* in the cycle after the 4th byte, then go IDLE.
REQ-025 A command byte before the 4th parameter SHALL discard staging; committed window unchanged.
REQ-026 Data bytes in IDLE SHALL be ignored by the decoder (still reported on byte_valid).
REQ-027 On entering RAMWR, cursor SHALL load (win_x0, win_y0) and the half-pixel flag SHALL clear.
REQ-028 In RAMWR, even data byte latches pix_data[15:8]; odd data byte completes pixel: pix_valid pulses one cycle after that byte's byte_valid with current cursor as pix_x/pix_y.
REQ-029 Cursor advance after each pixel: x<win_x1 -> x+1; else x=win_x0 and y<win_y1 -> y+1; else y=win_y0 (full wrap, frame restarts).
REQ-030 A command byte during RAMWR SHALL abort it; a pending half pixel is dropped, no pix_valid.
REQ-031 Window with x0>x1 or y0>y1 SHALL be committed as received; cursor then wraps to x0/y0 after every pixel in that axis (no error flag).
REQ-032 Arithmetic on coordinates SHALL be 16-bit unsigned.
REQ-033 Minimum supported spi_clk period: 4 clk cycles; faster input is undefined.

Reset
REQ-034 While rst=0: FSM IDLE; bit counter, shift register, byte_data, byte_dc, cmd_code, pix_*, all pulses = 0; win_x0=win_y0=0, win_x1=MAX_X, win_y1=MAX_Y; synchronizers loaded with spi_clk=0, cs=1.
REQ-035 Reset mid-byte or mid-pixel SHALL discard partial data; first edge after reset release starts bit 7.

Structure
REQ-036 Command codes (0x2A, 0x2B, 0x2C) and FSM state encodings SHALL live in a shared TFT package also used by the transmitter-side init/draw blocks.
REQ-037 Byte deserialization (REQ-019..022) SHALL be a sub-module spi_byte_rx; decoder and cursor stay in tft_spi_monitor.

Verification
REQ-038 Send cmd 0x2A, data 00 0A 00 13 -> cmd_valid once, cmd_code=0x2A; win_x0=10, win_x1=19 one cycle after 4th byte_valid.
REQ-039 Window x 10..11, y 5..6; 0x2C then 10 bytes -> 5 pix_valid at (10,5),(11,5),(10,6),(11,6),(10,5).
REQ-040 RAMWR data F8 00 -> pix_data=0xF800; then F8 followed by cmd 0x00 -> no pix_valid, FSM IDLE.
REQ-041 0x2B then 00 05 (two bytes) then 0x2A -> win_y0/win_y1 remain 0/479.
REQ-042 cs raised after 5 bits, lowered, byte 0xA5 sent -> exactly one byte_valid with 0xA5.
REQ-043 rst asserted after 3 bits of a byte -> all outputs at reset values; next full byte 0x3C decoded correctly.

Source files
------------

// File: rtl/tft_spi_monitor_pkg.sv
// rtl/tft_spi_monitor_pkg.sv - shared TFT command codes and decoder state encoding
package tft_spi_monitor_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CASET = 2'd1,
        ST_PASET = 2'd2,
        ST_RAMWR = 2'd3
    } tft_state_t;

    function automatic tft_state_t state_for_cmd(input logic [7:0] code);
        case (code)
            CMD_CASET: state_for_cmd = ST_CASET;
            CMD_PASET: state_for_cmd = ST_PASET;
            CMD_RAMWR: state_for_cmd = ST_RAMWR;
            default:   state_for_cmd = ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/tft_spi_monitor_if.sv
// rtl/tft_spi_monitor_if.sv - four-wire TFT SPI bus as seen by transmitter and monitor
interface tft_spi_if;
    logic spi_clk;
    logic spi_mosi;
    logic spi_dc;
    logic spi_cs;

    modport master (output spi_clk, output spi_mosi, output spi_dc, output spi_cs);
    modport slave  (input  spi_clk, input  spi_mosi, input  spi_dc, input  spi_cs);
endinterface

// File: rtl/tft_spi_monitor_spi_byte_rx.sv
// rtl/tft_spi_monitor_spi_byte_rx.sv - oversampled SPI mode-0 byte deserializer
module spi_byte_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_dc,
    input  logic       spi_cs,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       cmd_valid,
    output logic [7:0] cmd_code
);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] dc_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   clk_prev;
    logic [7:0]             shreg;
    logic [2:0]             bit_cnt;

    logic clk_s, mosi_s, dc_s, cs_s, clk_rise;
    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign dc_s     = dc_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync   <= '0;
            mosi_sync  <= '0;
            dc_sync    <= '0;
            cs_sync    <= '1;
            clk_prev   <= 1'b0;
            shreg      <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            byte_dc    <= 1'b0;
            cmd_valid  <= 1'b0;
            cmd_code   <= 8'h00;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0],  spi_clk};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            dc_sync    <= {dc_sync[SYNC_STAGES-2:0],   spi_dc};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0],   spi_cs};
            clk_prev   <= clk_s;
            byte_valid <= 1'b0;
            cmd_valid  <= 1'b0;
            // Deselect only resynchronises bit alignment; a partial byte is simply lost.
            if (cs_s) begin
                bit_cnt <= 3'd0;
            end else if (clk_rise) begin
                shreg   <= {shreg[6:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_valid <= 1'b1;
                    byte_data  <= {shreg[6:0], mosi_s};
                    byte_dc    <= dc_s;
                    if (!dc_s) begin
                        cmd_valid <= 1'b1;
                        cmd_code  <= {shreg[6:0], mosi_s};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tft_spi_monitor.sv
// rtl/tft_spi_monitor.sv - passive TFT SPI monitor: command decode, address window, pixel stream
module tft_spi_monitor
    import tft_spi_monitor_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] MAX_X       = 16'd319,
    parameter logic [15:0] MAX_Y       = 16'd479
) (
    input  logic        clk,
    input  logic        rst,
    tft_spi_if.slave    spi,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        byte_dc,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic [15:0] win_x0,
    output logic [15:0] win_x1,
    output logic [15:0] win_y0,
    output logic [15:0] win_y1,
    output logic        pix_valid,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [15:0] pix_data
);

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi.spi_clk),
        .spi_mosi   (spi.spi_mosi),
        .spi_dc     (spi.spi_dc),
        .spi_cs     (spi.spi_cs),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code)
    );

    tft_state_t  state;
    logic [1:0]  param_cnt;
    logic [23:0] stage;
    logic        half;
    logic [7:0]  pix_hi;
    logic [15:0] cur_x;
    logic [15:0] cur_y;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            param_cnt <= 2'd0;
            stage     <= 24'h0;
            half      <= 1'b0;
            pix_hi    <= 8'h00;
            cur_x     <= 16'h0;
            cur_y     <= 16'h0;
            win_x0    <= 16'h0;
            win_x1    <= MAX_X;
            win_y0    <= 16'h0;
            win_y1    <= MAX_Y;
            pix_valid <= 1'b0;
            pix_x     <= 16'h0;
            pix_y     <= 16'h0;
            pix_data  <= 16'h0;
        end else begin
            pix_valid <= 1'b0;
            if (cmd_valid) begin
                // Any command aborts whatever parameter or pixel was in flight.
                state     <= state_for_cmd(cmd_code);
                param_cnt <= 2'd0;
                stage     <= 24'h0;
                half      <= 1'b0;
                if (cmd_code == CMD_RAMWR) begin
                    cur_x <= win_x0;
                    cur_y <= win_y0;
                end
            end else if (byte_valid) begin
                case (state)
                    ST_CASET, ST_PASET: begin
                        stage     <= {stage[15:0], byte_data};
                        param_cnt <= param_cnt + 2'd1;
                        if (param_cnt == 2'd3) begin
                            if (state == ST_CASET) begin
                                win_x0 <= stage[23:8];
                                win_x1 <= {stage[7:0], byte_data};
                            end else begin
                                win_y0 <= stage[23:8];
                                win_y1 <= {stage[7:0], byte_data};
                            end
                            state <= ST_IDLE;
                        end
                    end
                    ST_RAMWR: begin
                        if (!half) begin
                            pix_hi <= byte_data;
                            half   <= 1'b1;
                        end else begin
                            half      <= 1'b0;
                            pix_valid <= 1'b1;
                            pix_data  <= {pix_hi, byte_data};
                            pix_x     <= cur_x;
                            pix_y     <= cur_y;
                            // Raster order inside the window; an inverted axis pins to its start.
                            if (cur_x < win_x1) begin
                                cur_x <= cur_x + 16'd1;
                            end else begin
                                cur_x <= win_x0;
                                cur_y <= (cur_y < win_y1) ? cur_y + 16'd1 : win_y0;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tft_spi_monitor.sv
// tb/tb_tft_spi_monitor.sv - directed self-checking bench for tft_spi_monitor
module tb_tft_spi_monitor;

    logic        clk;
    logic        rst;
    logic        byte_valid, byte_dc, cmd_valid, pix_valid;
    logic [7:0]  byte_data, cmd_code;
    logic [15:0] win_x0, win_x1, win_y0, win_y1;
    logic [15:0] pix_x, pix_y, pix_data;

    tft_spi_if spi_bus ();

    tft_spi_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi_bus.slave),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_dc    (byte_dc),
        .cmd_valid  (cmd_valid),
        .cmd_code   (cmd_code),
        .win_x0     (win_x0),
        .win_x1     (win_x1),
        .win_y0     (win_y0),
        .win_y1     (win_y1),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Monitor counters only ever increase; the stimulus block compares deltas.
    int          cyc = 0;
    int          byte_cnt = 0;
    int          cmd_cnt = 0;
    int          cmd_orphan = 0;
    int          pix_cnt = 0;
    int          last_bv = 0;
    int          win_delta = -1;
    logic [15:0] prev_x1 = 16'hxxxx;
    logic [15:0] px [0:63];
    logic [15:0] py [0:63];
    logic [15:0] pd [0:63];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (byte_valid === 1'b1) begin
            byte_cnt = byte_cnt + 1;
            last_bv  = cyc;
        end
        if (cmd_valid === 1'b1) begin
            cmd_cnt = cmd_cnt + 1;
            if (byte_valid !== 1'b1) cmd_orphan = cmd_orphan + 1;
        end
        if (pix_valid === 1'b1) begin
            px[pix_cnt % 64] = pix_x;
            py[pix_cnt % 64] = pix_y;
            pd[pix_cnt % 64] = pix_data;
            pix_cnt = pix_cnt + 1;
        end
        if (rst === 1'b1 && win_x1 !== prev_x1) win_delta = cyc - last_bv;
        prev_x1 = win_x1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            passed = passed + 1;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input logic dc);
        for (int i = 7; i > 7 - n; i--) begin
            spi_bus.spi_mosi = b[i];
            spi_bus.spi_dc   = dc;
            spi_bus.spi_clk  = 1'b0;
            cycles(4);
            spi_bus.spi_clk  = 1'b1;
            cycles(4);
        end
        spi_bus.spi_clk = 1'b0;
        cycles(6);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        send_bits(b, 8, 1'b0);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_bits(b, 8, 1'b1);
    endtask

    int b0, c0, p0;

    initial begin
        rst = 1'b0;
        spi_bus.spi_clk  = 1'b0;
        spi_bus.spi_mosi = 1'b0;
        spi_bus.spi_dc   = 1'b0;
        spi_bus.spi_cs   = 1'b1;
        cycles(5);
        check("rst_win_x0", 32'(win_x0), 32'd0);
        check("rst_win_x1", 32'(win_x1), 32'd319);
        check("rst_win_y1", 32'(win_y1), 32'd479);
        check("rst_byte_valid", 32'(byte_valid), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        rst = 1'b1;
        spi_bus.spi_cs = 1'b0;
        cycles(4);

        // Column address set
        b0 = byte_cnt; c0 = cmd_cnt;
        send_cmd(8'h2A);
        check("caset_cmd_code", 32'(cmd_code), 32'h2A);
        send_data(8'h00); send_data(8'h0A); send_data(8'h00); send_data(8'h13);
        check("caset_cmd_count", 32'(cmd_cnt - c0), 32'd1);
        check("caset_byte_count", 32'(byte_cnt - b0), 32'd5);
        check("caset_win_x0", 32'(win_x0), 32'd10);
        check("caset_win_x1", 32'(win_x1), 32'd19);
        check("caset_commit_latency", 32'(win_delta), 32'd1);

        // Truncated PASET must leave the row window alone
        send_cmd(8'h2B); send_data(8'h00); send_data(8'h05); send_cmd(8'h2A);
        check("paset_abort_y0", 32'(win_y0), 32'd0);
        check("paset_abort_y1", 32'(win_y1), 32'd479);

        // 2x2 window, five pixels to exercise full wrap
        send_cmd(8'h2A); send_data(8'h00); send_data(8'h0A); send_data(8'h00); send_data(8'h0B);
        send_cmd(8'h2B); send_data(8'h00); send_data(8'h05); send_data(8'h00); send_data(8'h06);
        check("win_y0", 32'(win_y0), 32'd5);
        check("win_y1", 32'(win_y1), 32'd6);
        p0 = pix_cnt;
        send_cmd(8'h2C);
        for (int i = 0; i < 10; i++) send_data(8'(8'h10 + i));
        check("ramwr_pix_count", 32'(pix_cnt - p0), 32'd5);
        check("pix0", {px[p0 % 64], py[p0 % 64]}, {16'd10, 16'd5});
        check("pix1", {px[(p0 + 1) % 64], py[(p0 + 1) % 64]}, {16'd11, 16'd5});
        check("pix2", {px[(p0 + 2) % 64], py[(p0 + 2) % 64]}, {16'd10, 16'd6});
        check("pix3", {px[(p0 + 3) % 64], py[(p0 + 3) % 64]}, {16'd11, 16'd6});
        check("pix4", {px[(p0 + 4) % 64], py[(p0 + 4) % 64]}, {16'd10, 16'd5});
        check("pix0_data", 32'(pd[p0 % 64]), 32'h1011);
        check("pix4_data", 32'(pd[(p0 + 4) % 64]), 32'h1819);

        // Half pixel dropped by a command, then data ignored in IDLE
        p0 = pix_cnt;
        send_cmd(8'h2C); send_data(8'hF8); send_data(8'h00);
        check("red_pix_count", 32'(pix_cnt - p0), 32'd1);
        check("red_pix_data", 32'(pix_data), 32'hF800);
        check("red_pix_xy", {pix_x, pix_y}, {16'd10, 16'd5});
        send_data(8'hF8); send_cmd(8'h00);
        send_data(8'h12); send_data(8'h34);
        check("abort_no_pix", 32'(pix_cnt - p0), 32'd1);
        check("abort_cmd_code", 32'(cmd_code), 32'h00);

        // Partial byte discarded by chip-select deassertion
        b0 = byte_cnt;
        send_bits(8'hFF, 5, 1'b1);
        spi_bus.spi_cs = 1'b1;
        cycles(10);
        spi_bus.spi_cs = 1'b0;
        cycles(4);
        send_data(8'hA5);
        check("cs_byte_count", 32'(byte_cnt - b0), 32'd1);
        check("cs_byte_data", 32'(byte_data), 32'hA5);
        check("cs_byte_dc", 32'(byte_dc), 32'd1);

        // Reset in the middle of a byte
        send_bits(8'hE0, 3, 1'b1);
        rst = 1'b0;
        cycles(5);
        check("mid_rst_byte_data", 32'(byte_data), 32'd0);
        check("mid_rst_cmd_code", 32'(cmd_code), 32'd0);
        check("mid_rst_win", {win_x0, win_x1}, {16'd0, 16'd319});
        check("mid_rst_win_y", {win_y0, win_y1}, {16'd0, 16'd479});
        check("mid_rst_pix", {pix_x, pix_data}, 32'd0);
        rst = 1'b1;
        cycles(4);
        b0 = byte_cnt;
        send_cmd(8'h3C);
        check("post_rst_byte_count", 32'(byte_cnt - b0), 32'd1);
        check("post_rst_byte_data", 32'(byte_data), 32'h3C);
        check("post_rst_cmd_code", 32'(cmd_code), 32'h3C);
        check("post_rst_byte_dc", 32'(byte_dc), 32'd0);
        check("cmd_valid_aligned", 32'(cmd_orphan), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
